// File: rtl/qusim_pkg.sv
// Shared types and constants for the amplitude-register consumers.
// Word layout: {re[31:16], im[15:0]}, signed Q2.14 parts.
package qusim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_REQ,
        ST_WAIT,
        ST_CALC,
        ST_OUT,
        ST_FIN
    } state_e;

    localparam int N_WORDS = 4;
    localparam int IDX_W   = 2;
    localparam int AMP_W   = 16;
    localparam int WORD_W  = 2 * AMP_W;
    localparam int TOTAL_W = 34;

    localparam int RE_HI = 31;
    localparam int RE_LO = 16;
    localparam int IM_HI = 15;
    localparam int IM_LO = 0;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    // 1.0 in Q4.28 and the accepted absolute deviation from it
    localparam logic [WORD_W-1:0] NORM_TARGET = 32'h1000_0000;
    localparam logic [WORD_W-1:0] NORM_TOL    = 32'h0010_0000;

endpackage

// File: rtl/cplx_mag2.sv
// Combinational squared magnitude of a signed complex amplitude: re^2 + im^2.
// Worst case (-32768, -32768) gives exactly 2^31, so the unsigned sum never wraps.
module cplx_mag2
    import qusim_pkg::*;
(
    input  logic signed [AMP_W-1:0]  re,
    input  logic signed [AMP_W-1:0]  im,
    output logic        [WORD_W-1:0] mag2
);

    logic signed [WORD_W-1:0] re_x;
    logic signed [WORD_W-1:0] im_x;
    logic signed [WORD_W-1:0] re_sq;
    logic signed [WORD_W-1:0] im_sq;

    always_comb begin
        re_x  = {{AMP_W{re[AMP_W-1]}}, re};
        im_x  = {{AMP_W{im[AMP_W-1]}}, im};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        mag2  = $unsigned(re_sq) + $unsigned(im_sq);
    end

endmodule

// File: rtl/amp_prob_drain.sv
// Drains the 4-entry amplitude array, emits |a|^2 per word on valid/ack and a run total.
// Optional: define PROB_NORM_CHECK_EN to flag totals that stray from 1.0 (norm_err).
//
// state | meaning
// IDLE  | waiting for start
// CLR   | pulse arr_rst to rewind the array read pointer
// REQ   | pulse emit for the current index
// WAIT  | array answers here; missing ready aborts the run
// CALC  | register |a|^2 and accumulate
// OUT   | hold prob_* until acked
// FIN   | done pulse, total stable
module amp_prob_drain
    import qusim_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               arr_rst,
    output logic               emit,
    input  logic [WORD_W-1:0]  arr_data,
    input  logic               arr_ready,
    output logic [WORD_W-1:0]  prob_data,
    output logic [IDX_W-1:0]   prob_index,
    output logic               prob_valid,
    input  logic               prob_ack,
    output logic [TOTAL_W-1:0] total,
    output logic               done,
    output logic               err,
    output logic               norm_err
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [WORD_W-1:0]   prob_q, prob_d;
    logic [TOTAL_W-1:0]  total_q, total_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   mag2;

    cplx_mag2 u_mag2 (
        .re   (data_q[RE_HI:RE_LO]),
        .im   (data_q[IM_HI:IM_LO]),
        .mag2 (mag2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CLR;
            ST_CLR:  state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: state_d = arr_ready ? ST_CALC : ST_FIN;
            ST_CALC: state_d = ST_OUT;
            ST_OUT:  if (prob_ack) state_d = (idx_q == LAST_IDX) ? ST_FIN : ST_REQ;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        arr_rst    = (state_q == ST_CLR);
        emit       = (state_q == ST_REQ);
        prob_valid = (state_q == ST_OUT);
        done       = (state_q == ST_FIN);
        prob_data  = prob_q;
        prob_index = idx_q;
        total      = total_q;
        err        = err_q;
    end

    always_comb begin
        idx_d   = idx_q;
        data_d  = data_q;
        prob_d  = prob_q;
        total_d = total_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    total_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (arr_ready) data_d = arr_data;
                else           err_d  = 1'b1;
            end
            ST_CALC: begin
                prob_d  = mag2;
                total_d = total_q + {2'b00, mag2};
            end
            ST_OUT: begin
                if (prob_ack && idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            data_q  <= '0;
            prob_q  <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            data_q  <= data_d;
            prob_q  <= prob_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

`ifdef PROB_NORM_CHECK_EN
    logic               norm_err_q, norm_err_d;
    logic [TOTAL_W-1:0] target_x;
    logic [TOTAL_W-1:0] dev;

    always_comb begin
        target_x   = {2'b00, NORM_TARGET};
        dev        = (total_q >= target_x) ? (total_q - target_x) : (target_x - total_q);
        norm_err_d = norm_err_q;
        if (state_q == ST_IDLE && start) begin
            norm_err_d = 1'b0;
        end else if (state_q == ST_FIN && dev > {2'b00, NORM_TOL}) begin
            norm_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            norm_err_q <= 1'b0;
        end else begin
            norm_err_q <= norm_err_d;
        end
    end

    assign norm_err = norm_err_q;
`else
    assign norm_err = 1'b0;
`endif

endmodule

// File: tb/tb_amp_prob_drain.sv
// Bench for amp_prob_drain: directed test-plan runs plus randomized runs against a behavioural model.
module tb_amp_prob_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, arr_rst, emit;
    logic [31:0] arr_data;
    logic        arr_ready;
    logic [31:0] prob_data;
    logic [1:0]  prob_index;
    logic        prob_valid;
    logic        prob_ack = 1'b0;
    logic [33:0] total;
    logic        done, err, norm_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    amp_prob_drain dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .arr_rst    (arr_rst),
        .emit       (emit),
        .arr_data   (arr_data),
        .arr_ready  (arr_ready),
        .prob_data  (prob_data),
        .prob_index (prob_index),
        .prob_valid (prob_valid),
        .prob_ack   (prob_ack),
        .total      (total),
        .done       (done),
        .err        (err),
        .norm_err   (norm_err)
    );

    // Array model: answers one cycle after emit; the response numbered drop_idx comes back not-ready.
    logic [31:0] mem [4];
    int          drop_idx = -1;
    int          ptr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= 0;
            arr_ready <= 1'b0;
            arr_data  <= '0;
        end else if (arr_rst) begin
            ptr       <= 0;
            arr_ready <= 1'b0;
        end else if (emit) begin
            arr_data  <= mem[ptr % 4];
            arr_ready <= (ptr != drop_idx);
            ptr       <= ptr + 1;
        end else begin
            arr_ready <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint mag2(input logic [31:0] w);
        longint re;
        longint im;
        re = $signed(w[31:16]);
        im = $signed(w[15:0]);
        return re * re + im * im;
    endfunction

    function automatic bit exp_norm(input longint t);
`ifdef PROB_NORM_CHECK_EN
        longint d;
        d = t - 64'h1000_0000;
        if (d < 0) d = -d;
        return d > 64'h0010_0000;
`else
        return 1'b0;
`endif
    endfunction

    // One drain run. drop >= 0 makes that word's response not-ready; exp_cycles < 0 skips latency check.
    task automatic run(input logic [31:0] words [4], input int delay [4], input bit ack_always,
                       input int drop, input bit restart_mid, input int exp_cycles);
        longint exp_total = 0;
        int     n_exp, cycles = 0, emits = 0, clrs = 0, seen = 0, wait_cnt = 0;
        bit     fin = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = words[i];
        drop_idx = drop;
        n_exp = (drop >= 0) ? drop : 4;
        for (int i = 0; i < n_exp; i++) exp_total += mag2(words[i]);

        @(negedge clk);
        start    = 1'b1;
        prob_ack = ack_always;
        @(negedge clk);
        while (!fin && cycles < 400) begin
            cycles++;
            start = (restart_mid && cycles == 6);
            if (!ack_always) prob_ack = 1'b0;
            if (emit) emits++;
            if (arr_rst) clrs++;
            if (cycles == 1) begin
                chk("err_cleared_on_start", err, 1'b0);
                chk("total_cleared_on_start", total, 34'h0);
                chk("norm_cleared_on_start", norm_err, 1'b0);
            end
            if (prob_valid) begin
                chk("prob_index", prob_index, seen[1:0]);
                chk("prob_data", prob_data, mag2(words[seen % 4]));
                chk("emit_while_valid", emit, 1'b0);
                if (ack_always || wait_cnt >= delay[seen % 4]) begin
                    prob_ack = 1'b1;
                    seen++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (done) fin = 1'b1;
            else @(negedge clk);
        end
        start = 1'b0;
        chk("done_reached", fin, 1'b1);
        chk("total", total, exp_total);
        chk("err", err, (drop >= 0));
        chk("emit_count", emits, (drop >= 0) ? drop + 1 : 4);
        chk("arr_rst_count", clrs, 1);
        chk("outputs_count", seen, n_exp);
        if (exp_cycles >= 0) chk("latency", cycles, exp_cycles);
        @(negedge clk);
        if (!ack_always) prob_ack = 1'b0;
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_run", busy, 1'b0);
        chk("norm_err", norm_err, exp_norm(exp_total));
        prob_ack = 1'b0;
        drop_idx = -1;
    endtask

    initial begin
        logic [31:0] w [4];
        int          d [4];
        int          d0 [4];
        bit          got;
        d0 = '{0, 0, 0, 0};

        // Reset state
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", prob_valid, 1'b0);
        chk("rst_total", total, 34'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_emit", emit, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic drain, ack tied high: done in the 19th cycle counting the start cycle, i.e. 18 cycles later
        w = '{32'h2000_2000, 32'h2000_2000, 32'h2000_2000, 32'h2000_2000};
        run(w, d0, 1'b1, -1, 1'b0, 18);
        chk("basic_total", total, 34'h0_2000_0000);

        // Sign handling
        w = '{32'h4000_0000, 32'h0000_C000, 32'h8000_8000, 32'h0000_0000};
        run(w, d0, 1'b1, -1, 1'b0, 18);
        chk("sign_total", total, 34'h0_A000_0000);

        // Backpressure at index 1, plus an ignored start while busy
        d = '{0, 5, 0, 0};
        run(w, d, 1'b0, -1, 1'b1, -1);

        // Protocol error on second WAIT, then a clean run clears err
        w = '{32'h2000_2000, 32'h1234_5678, 32'h7FFF_7FFF, 32'h0001_0001};
        run(w, d0, 1'b1, 1, 1'b0, -1);
        run(w, d0, 1'b0, -1, 1'b0, -1);

        // Reset mid-run while in OUT
        w = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
        for (int i = 0; i < 4; i++) mem[i] = w[i];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (prob_valid) got = 1'b1;
            else @(negedge clk);
        end
        chk("reached_out", got, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", prob_valid, 1'b0);
        chk("midrst_data", prob_data, 32'h0);
        chk("midrst_index", prob_index, 2'd0);
        chk("midrst_total", total, 34'h0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_emit", emit, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run(w, d0, 1'b1, -1, 1'b0, 18);

        // Normalisation: exactly 1.0 then 4.0
        w = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
        run(w, d0, 1'b1, -1, 1'b0, 18);
        w = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
        run(w, d0, 1'b1, -1, 1'b0, 18);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            int drop;
            for (int i = 0; i < 4; i++) begin
                w[i] = $urandom;
                d[i] = $urandom_range(0, 3);
            end
            if (r == 0) w[2] = 32'h8000_8000;
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            run(w, d, $urandom_range(0, 1) == 1, drop, $urandom_range(0, 1) == 1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
